shift_reg_4b: RTL



---
 rtl/shift_reg_4b.sv | 94 +++++++++
 1 files changed

// File: rtl/shift_reg_4b.sv
// Four-bit universal shift register: hold, serial shift, rotate and parallel load,
// plus a saturating count of 0->1 transitions on q for switching-activity estimation.
module shift_reg_4b #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             s_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             s_out,
    output logic [CNT_W-1:0] rise_cnt
);

    typedef enum logic [1:0] {
        ModeHold   = 2'b00,
        ModeShift  = 2'b01,
        ModeRotate = 2'b10,
        ModeLoad   = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             s_out_q, s_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] rises;
    logic [CNT_W:0]   pop;
    logic [CNT_W:0]   sum;

    always_comb begin
        q_d     = q_q;
        s_out_d = s_out_q;
        unique case (mode_e'(mode))
            ModeHold: begin
                q_d     = q_q;
                s_out_d = s_out_q;
            end
            ModeShift: begin
                if (dir) begin
                    q_d     = {q_q[WIDTH-2:0], s_in};
                    s_out_d = q_q[WIDTH-1];
                end else begin
                    q_d     = {s_in, q_q[WIDTH-1:1]};
                    s_out_d = q_q[0];
                end
            end
            ModeRotate: begin
                if (dir) begin
                    q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    s_out_d = q_q[WIDTH-1];
                end else begin
                    q_d     = {q_q[0], q_q[WIDTH-1:1]};
                    s_out_d = q_q[0];
                end
            end
            ModeLoad: begin
                q_d     = d;
                s_out_d = 1'b0;
            end
        endcase
    end

    // The extra sum bit flags overflow; any overflow clamps to all-ones.
    always_comb begin
        rises = ~q_q & q_d;
        pop   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{CNT_W{1'b0}}, rises[i]};
        end
        sum   = {1'b0, cnt_q} + pop;
        cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            s_out_q <= 1'b0;
            cnt_q   <= '0;
        end else if (enb) begin
            q_q     <= q_d;
            s_out_q <= s_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q        = q_q;
    assign s_out    = s_out_q;
    assign rise_cnt = cnt_q;

endmodule
